flight_mode_sequencer: RTL and testbench
========================================

# flight_mode_sequencer

Command sequencer that sits directly upstream of the per-axis position datapath and drives its one-hot `mode_selector` and `pos_selector` buses. It accepts flight commands over a valid/ready handshake. It runs a charge → jump → cooldown warp sequence so that the warp position is selected for exactly one cycle. It also guarantees both selector buses are always legal one-hot values.

## Interface
- `CHARGE_CYCLES`, 8: cycles spent in CHARGE before the jump; legal range 1..255.
- `COOLDOWN_CYCLES`, 4: cycles spent in COOLDOWN after the jump; legal range 1..255.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_op` input 3: command code.
  - 0 STOP, 1 ATTACK, 2 DEFENSE, 3 STEALTH, 4 WARP, 5 ABORT.
  - 6 and 7 are illegal.
- `cmd_ready` output 1: the sequencer can accept a command this cycle.
- `mode_selector` output 4: velocity select, one-hot.
  - 0001 stop (zero velocity), 0010 attack, 0100 defense, 1000 stealth.
- `pos_selector` output 4: position select, one-hot.
  - 0001 clear, 0010 normal (position + velocity), 0100 warp.
  - 1000 is never driven.
- `state_o` output 3: current state encoding (CLEAR=0, STOPPED=1, CRUISE=2, CHARGE=3, JUMP=4, COOLDOWN=5).
- `cmd_err` output 1: one-cycle pulse when a command is rejected.
- `jump_count` output 8: number of completed jumps; saturates at 255.

## Operation
- A handshake occurs on a rising edge where `cmd_valid` and `cmd_ready` are both 1. Every handshaken command is consumed, including rejected ones.
- All outputs are registered.
- Reset values, applied whenever `rst_n`=0 at an edge, in any state:
  - state CLEAR, `mode_selector`=0001, `pos_selector`=0001.
  - `cmd_ready`=0, `cmd_err`=0, `jump_count`=0.
  - Charge/cooldown counters cleared; saved mode = 0001.
- CLEAR: zeroes the downstream position. Lasts one cycle after reset release, then moves to STOPPED. `cmd_ready`=0.
- STOPPED: `mode_selector`=0001, `pos_selector`=0010, `cmd_ready`=1.
  - ATTACK, DEFENSE or STEALTH → CRUISE with the matching mode.
  - STOP → stay in STOPPED.
  - WARP, ABORT and illegal codes → `cmd_err`.
- CRUISE: `pos_selector`=0010, `cmd_ready`=1.
  - ATTACK, DEFENSE or STEALTH → change mode, stay in CRUISE.
  - STOP → STOPPED.
  - WARP → save the current mode, load the counter with CHARGE_CYCLES-1, go to CHARGE.
  - ABORT and illegal codes → `cmd_err`.
- CHARGE: `mode_selector`=0001 (hold position), `pos_selector`=0010, `cmd_ready`=1.
  - ABORT → CRUISE with the saved mode; counter cleared.
  - Any other command → `cmd_err`, dropped.
  - When the counter reaches 0 and no ABORT is present → JUMP.
  - If ABORT arrives on the same edge the counter reaches 0, ABORT wins and no jump occurs.
- JUMP: lasts exactly one cycle; `mode_selector`=0001, `pos_selector`=0100, `cmd_ready`=0.
  - `jump_count` increments, saturating at 255.
  - Load the counter with COOLDOWN_CYCLES-1, then go to COOLDOWN.
- COOLDOWN: `mode_selector`=0001, `pos_selector`=0010, `cmd_ready`=0. When the counter reaches 0 → STOPPED. The saved mode is discarded.
- Invariants:
  - Both selectors are exactly one-hot in every cycle.
  - `pos_selector`=0100 only in JUMP.
  - `pos_selector`=0001 only in CLEAR.

## Timing
- A command handshaken at edge N is reflected in `state_o`, the selectors and `cmd_err` from edge N onward, i.e. visible during cycle N+1. `cmd_err` is high for that one cycle only.
- WARP accepted at edge N (no abort):
  - CHARGE occupies cycles N+1 .. N+CHARGE_CYCLES.
  - JUMP occupies cycle N+CHARGE_CYCLES+1.
  - COOLDOWN occupies the following COOLDOWN_CYCLES cycles.
  - `cmd_ready` is 1 again in cycle N+CHARGE_CYCLES+COOLDOWN_CYCLES+2.
- `cmd_ready` depends only on the registered state; there is no combinational path from `cmd_valid` to `cmd_ready`.
- After `rst_n` rises, the first possible handshake is at the second edge (CLEAR lasts one cycle).

## Test plan
- Reset, then release and hold `cmd_valid`=0:
  - Reset values are 0001/0001 with `cmd_ready`=0.
  - One cycle later the sequencer is in STOPPED with 0001/0010 and `cmd_ready`=1.
- ATTACK, then STEALTH, then STOP:
  - `mode_selector` steps 0010 → 1000 → 0001, each one cycle after its handshake.
  - `pos_selector` stays 0010 throughout.
- DEFENSE, then WARP at edge N (defaults):
  - Mode is 0001 for cycles N+1..N+8.
  - `pos_selector`=0100 only in cycle N+9; `jump_count`=1.
  - `cmd_ready`=0 in cycles N+9..N+13 and is 1 in N+14; final state STOPPED.
- DEFENSE, WARP, then ABORT on the 3rd CHARGE cycle: returns to CRUISE with mode 0100, no 0100 on `pos_selector`, and `jump_count` unchanged.
- Error and reset cases:
  - WARP in STOPPED, cmd_op=7, and ATTACK during CHARGE each give a single-cycle `cmd_err` and no state change.
  - `rst_n` low during COOLDOWN returns all outputs to their reset values at that edge.

Source files
------------

// File: rtl/flight_mode_sequencer.sv
// flight_mode_sequencer
//   Command sequencer for the per-axis position datapath. It accepts flight
//   commands over a valid/ready handshake and drives the one-hot velocity
//   (mode_selector) and position (pos_selector) selector buses. A WARP command
//   runs charge -> jump -> cooldown so that the warp position is selected for
//   exactly one cycle.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   cmd_valid     command present
//   cmd_op[2:0]   0 STOP, 1 ATTACK, 2 DEFENSE, 3 STEALTH, 4 WARP, 5 ABORT
//   cmd_ready     command can be accepted this cycle (registered)
//   mode_selector one-hot velocity select: 0001 stop, 0010 attack,
//                 0100 defense, 1000 stealth
//   pos_selector  one-hot position select: 0001 clear, 0010 normal, 0100 warp
//   state_o       current state (CLEAR=0 .. COOLDOWN=5)
//   cmd_err       one-cycle pulse when a handshaken command is rejected
//   jump_count    completed jumps, saturating at 255
module flight_mode_sequencer #(
   parameter int unsigned CHARGE_CYCLES   = 8,
   parameter int unsigned COOLDOWN_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [2:0] cmd_op,
   output logic       cmd_ready,
   output logic [3:0] mode_selector,
   output logic [3:0] pos_selector,
   output logic [2:0] state_o,
   output logic       cmd_err,
   output logic [7:0] jump_count
);

   typedef enum logic [2:0] {
      S_CLEAR    = 3'd0,
      S_STOPPED  = 3'd1,
      S_CRUISE   = 3'd2,
      S_CHARGE   = 3'd3,
      S_JUMP     = 3'd4,
      S_COOLDOWN = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      OP_STOP    = 3'd0,
      OP_ATTACK  = 3'd1,
      OP_DEFENSE = 3'd2,
      OP_STEALTH = 3'd3,
      OP_WARP    = 3'd4,
      OP_ABORT   = 3'd5
   } op_e;

   localparam logic [3:0] MODE_STOP  = 4'b0001;
   localparam logic [3:0] POS_CLEAR  = 4'b0001;
   localparam logic [3:0] POS_NORMAL = 4'b0010;
   localparam logic [3:0] POS_WARP   = 4'b0100;

   // Counters are loaded with N-1 so a phase of N cycles ends on the edge
   // where the counter is already zero.
   localparam logic [7:0] CHARGE_LOAD   = 8'(CHARGE_CYCLES - 1);
   localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_CYCLES - 1);

   state_e     r_state;
   logic [3:0] r_mode;
   logic [3:0] r_pos;
   logic       r_ready;
   logic       r_err;
   logic [7:0] r_jump_count;
   logic [7:0] r_cnt;
   logic [3:0] r_saved_mode;
   logic       w_hs;

   function automatic logic [3:0] op_mode(input logic [2:0] op);
      case (op)
         OP_ATTACK:  op_mode = 4'b0010;
         OP_DEFENSE: op_mode = 4'b0100;
         OP_STEALTH: op_mode = 4'b1000;
         default:    op_mode = MODE_STOP;
      endcase
   endfunction

   // cmd_ready is a register, so the handshake never feeds back into it.
   assign w_hs = cmd_valid & r_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_CLEAR;
         r_mode       <= MODE_STOP;
         r_pos        <= POS_CLEAR;
         r_ready      <= 1'b0;
         r_err        <= 1'b0;
         r_jump_count <= '0;
         r_cnt        <= '0;
         r_saved_mode <= MODE_STOP;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_CLEAR: begin
               r_state <= S_STOPPED;
               r_mode  <= MODE_STOP;
               r_pos   <= POS_NORMAL;
               r_ready <= 1'b1;
            end
            S_STOPPED: begin
               if (w_hs) begin
                  case (cmd_op)
                     OP_ATTACK, OP_DEFENSE, OP_STEALTH: begin
                        r_state <= S_CRUISE;
                        r_mode  <= op_mode(cmd_op);
                     end
                     OP_STOP: ;
                     default: r_err <= 1'b1;
                  endcase
               end
            end
            S_CRUISE: begin
               if (w_hs) begin
                  case (cmd_op)
                     OP_ATTACK, OP_DEFENSE, OP_STEALTH: r_mode <= op_mode(cmd_op);
                     OP_STOP: begin
                        r_state <= S_STOPPED;
                        r_mode  <= MODE_STOP;
                     end
                     OP_WARP: begin
                        r_state      <= S_CHARGE;
                        r_saved_mode <= r_mode;
                        r_mode       <= MODE_STOP;
                        r_cnt        <= CHARGE_LOAD;
                     end
                     default: r_err <= 1'b1;
                  endcase
               end
            end
            S_CHARGE: begin
               // ABORT takes priority over an expiring charge counter.
               if (w_hs && (cmd_op == OP_ABORT)) begin
                  r_state <= S_CRUISE;
                  r_mode  <= r_saved_mode;
                  r_cnt   <= '0;
               end else begin
                  if (w_hs) r_err <= 1'b1;
                  if (r_cnt == 8'd0) begin
                     r_state <= S_JUMP;
                     r_pos   <= POS_WARP;
                     r_ready <= 1'b0;
                     if (r_jump_count != 8'hFF) r_jump_count <= r_jump_count + 8'd1;
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end
            end
            S_JUMP: begin
               r_state <= S_COOLDOWN;
               r_pos   <= POS_NORMAL;
               r_cnt   <= COOLDOWN_LOAD;
            end
            S_COOLDOWN: begin
               if (r_cnt == 8'd0) begin
                  r_state      <= S_STOPPED;
                  r_ready      <= 1'b1;
                  r_saved_mode <= MODE_STOP;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: begin
               r_state <= S_CLEAR;
               r_mode  <= MODE_STOP;
               r_pos   <= POS_CLEAR;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready     = r_ready;
   assign mode_selector = r_mode;
   assign pos_selector  = r_pos;
   assign state_o       = r_state;
   assign cmd_err       = r_err;
   assign jump_count    = r_jump_count;

endmodule

// File: tb/tb_flight_mode_sequencer.sv
// tb_flight_mode_sequencer
//   Scoreboard bench: each stimulus cycle pushes the outputs expected after
//   the next rising edge; a monitor pops and compares them 1 ns after that edge.
module tb_flight_mode_sequencer;

   localparam int unsigned CH = 8;
   localparam int unsigned CD = 4;

   localparam logic [2:0] S_CLEAR = 3'd0, S_STOP = 3'd1, S_CRUISE = 3'd2,
                          S_CHARGE = 3'd3, S_JUMP = 3'd4, S_COOL = 3'd5;
   localparam logic [2:0] OP_STOP = 3'd0, OP_ATTACK = 3'd1, OP_DEFENSE = 3'd2,
                          OP_STEALTH = 3'd3, OP_WARP = 3'd4, OP_ABORT = 3'd5;
   localparam logic [3:0] M_STOP = 4'b0001, M_ATT = 4'b0010, M_DEF = 4'b0100,
                          M_STL = 4'b1000;
   localparam logic [3:0] P_CLR = 4'b0001, P_NRM = 4'b0010, P_WRP = 4'b0100;

   typedef struct {
      logic [2:0] st;
      logic [3:0] md;
      logic [3:0] ps;
      logic       rdy;
      logic       err;
      logic [7:0] jc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic [2:0] cmd_op;
   logic       cmd_ready;
   logic [3:0] mode_selector;
   logic [3:0] pos_selector;
   logic [2:0] state_o;
   logic       cmd_err;
   logic [7:0] jump_count;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic [7:0] jc;

   flight_mode_sequencer #(
      .CHARGE_CYCLES  (CH),
      .COOLDOWN_CYCLES(CD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_op       (cmd_op),
      .cmd_ready    (cmd_ready),
      .mode_selector(mode_selector),
      .pos_selector (pos_selector),
      .state_o      (state_o),
      .cmd_err      (cmd_err),
      .jump_count   (jump_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic step(input logic rst, input logic v, input logic [2:0] op,
                       input logic [2:0] st, input logic [3:0] md, input logic [3:0] ps,
                       input logic rdy, input logic err, input logic [7:0] jexp);
      exp_t e;
      rst_n     = rst;
      cmd_valid = v;
      cmd_op    = op;
      e.st = st; e.md = md; e.ps = ps; e.rdy = rdy; e.err = err; e.jc = jexp;
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

   // From STOPPED: enter cruise with op, warp, run the full sequence back to
   // STOPPED. Commands offered while cmd_ready=0 must be ignored.
   task automatic warp_full(input logic [2:0] op, input logic [3:0] md, input logic [7:0] j0);
      logic [7:0] j1;
      j1 = sat_inc(j0);
      step(1, 1, op,      S_CRUISE, md,     P_NRM, 1, 0, j0);
      step(1, 1, OP_WARP, S_CHARGE, M_STOP, P_NRM, 1, 0, j0);
      for (int unsigned i = 1; i < CH; i++)
         step(1, 0, OP_STOP, S_CHARGE, M_STOP, P_NRM, 1, 0, j0);
      step(1, 0, OP_STOP, S_JUMP, M_STOP, P_WRP, 0, 0, j1);
      for (int unsigned i = 0; i < CD; i++)
         step(1, 1, OP_ATTACK, S_COOL, M_STOP, P_NRM, 0, 0, j1);
      step(1, 1, OP_ATTACK, S_STOP, M_STOP, P_NRM, 1, 0, j1);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("state",   32'(state_o),       32'(e.st));
            chk("mode",    32'(mode_selector), 32'(e.md));
            chk("pos",     32'(pos_selector),  32'(e.ps));
            chk("ready",   32'(cmd_ready),     32'(e.rdy));
            chk("err",     32'(cmd_err),       32'(e.err));
            chk("jcount",  32'(jump_count),    32'(e.jc));
            chk("mode_1h", 32'($onehot(mode_selector)), 32'd1);
            chk("pos_1h",  32'($onehot(pos_selector)),  32'd1);
         end
      end
   end

   initial begin
      // Reset, then release: CLEAR one cycle (no handshake), then STOPPED.
      step(0, 0, OP_STOP,   S_CLEAR, M_STOP, P_CLR, 0, 0, 0);
      step(0, 0, OP_STOP,   S_CLEAR, M_STOP, P_CLR, 0, 0, 0);
      step(1, 1, OP_ATTACK, S_STOP,  M_STOP, P_NRM, 1, 0, 0);
      step(1, 0, OP_STOP,   S_STOP,  M_STOP, P_NRM, 1, 0, 0);

      // Mode stepping in cruise.
      step(1, 1, OP_ATTACK,  S_CRUISE, M_ATT,  P_NRM, 1, 0, 0);
      step(1, 1, OP_STEALTH, S_CRUISE, M_STL,  P_NRM, 1, 0, 0);
      step(1, 1, OP_STOP,    S_STOP,   M_STOP, P_NRM, 1, 0, 0);

      // Full warp from DEFENSE.
      warp_full(OP_DEFENSE, M_DEF, 8'd0);

      // ABORT on the third charge cycle.
      step(1, 1, OP_DEFENSE, S_CRUISE, M_DEF,  P_NRM, 1, 0, 1);
      step(1, 1, OP_WARP,    S_CHARGE, M_STOP, P_NRM, 1, 0, 1);
      step(1, 0, OP_STOP,    S_CHARGE, M_STOP, P_NRM, 1, 0, 1);
      step(1, 0, OP_STOP,    S_CHARGE, M_STOP, P_NRM, 1, 0, 1);
      step(1, 1, OP_ABORT,   S_CRUISE, M_DEF,  P_NRM, 1, 0, 1);
      for (int unsigned i = 0; i < CH + 2; i++)
         step(1, 0, OP_STOP, S_CRUISE, M_DEF, P_NRM, 1, 0, 1);

      // Rejections.
      step(1, 1, OP_STOP,   S_STOP,   M_STOP, P_NRM, 1, 0, 1);
      step(1, 1, OP_WARP,   S_STOP,   M_STOP, P_NRM, 1, 1, 1);
      step(1, 0, OP_STOP,   S_STOP,   M_STOP, P_NRM, 1, 0, 1);
      step(1, 1, 3'd7,      S_STOP,   M_STOP, P_NRM, 1, 1, 1);
      step(1, 0, OP_STOP,   S_STOP,   M_STOP, P_NRM, 1, 0, 1);
      step(1, 1, OP_ATTACK, S_CRUISE, M_ATT,  P_NRM, 1, 0, 1);
      step(1, 1, OP_ABORT,  S_CRUISE, M_ATT,  P_NRM, 1, 1, 1);
      step(1, 1, 3'd6,      S_CRUISE, M_ATT,  P_NRM, 1, 1, 1);
      step(1, 1, OP_WARP,   S_CHARGE, M_STOP, P_NRM, 1, 0, 1);
      step(1, 1, OP_ATTACK, S_CHARGE, M_STOP, P_NRM, 1, 1, 1);
      step(1, 0, OP_STOP,   S_CHARGE, M_STOP, P_NRM, 1, 0, 1);
      step(1, 1, OP_ABORT,  S_CRUISE, M_ATT,  P_NRM, 1, 0, 1);

      // ABORT on the edge where the charge counter expires: no jump.
      step(1, 1, OP_WARP, S_CHARGE, M_STOP, P_NRM, 1, 0, 1);
      for (int unsigned i = 1; i < CH; i++)
         step(1, 0, OP_STOP, S_CHARGE, M_STOP, P_NRM, 1, 0, 1);
      step(1, 1, OP_ABORT, S_CRUISE, M_ATT, P_NRM, 1, 0, 1);
      for (int unsigned i = 0; i < 3; i++)
         step(1, 0, OP_STOP, S_CRUISE, M_ATT, P_NRM, 1, 0, 1);

      // Reset asserted during cooldown.
      step(1, 1, OP_WARP, S_CHARGE, M_STOP, P_NRM, 1, 0, 1);
      for (int unsigned i = 1; i < CH; i++)
         step(1, 0, OP_STOP, S_CHARGE, M_STOP, P_NRM, 1, 0, 1);
      step(1, 0, OP_STOP, S_JUMP, M_STOP, P_WRP, 0, 0, 2);
      step(1, 0, OP_STOP, S_COOL, M_STOP, P_NRM, 0, 0, 2);
      step(1, 0, OP_STOP, S_COOL, M_STOP, P_NRM, 0, 0, 2);
      step(0, 0, OP_STOP, S_CLEAR, M_STOP, P_CLR, 0, 0, 0);
      step(1, 0, OP_STOP, S_STOP,  M_STOP, P_NRM, 1, 0, 0);

      // jump_count saturation over 256 jumps.
      jc = 8'd0;
      for (int unsigned k = 0; k < 256; k++) begin
         warp_full(OP_STEALTH, M_STL, jc);
         jc = sat_inc(jc);
      end

      @(posedge clk);
      #3;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
